// File: rtl/ex_pkg.sv
// Shared constants and encodings for the ex_top push-register frame sequencer.
// Consumed by ex_src_mux and ex_push_arb.
package ex_pkg;

    localparam int          NBYTE       = 32;
    localparam int          CNT_W       = $clog2(NBYTE);
    localparam logic [7:0]  HDR         = 8'hA5;
    localparam logic [9:0]  FX_PORT_OFS = 10'h080;
    localparam logic [15:0] TIMEOUT     = 16'd50000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CKSUM = 2'd2
    } state_t;

    typedef enum logic {
        SRC_SPI = 1'b0,
        SRC_FX  = 1'b1
    } src_t;

endpackage

// File: rtl/ex_src_mux.sv
// Decodes SPI / fx-bus byte events, resolves header tie-breaks in IDLE and
// passes only the granted source's bytes once a frame is in progress.
module ex_src_mux
    import ex_pkg::*;
(
    input  logic        i_idle,
    input  src_t        i_grant,
    input  logic        i_mcu_sel,
    input  logic        i_spi_vld,
    input  logic [7:0]  i_spi_data,
    input  logic        i_fx_wr,
    input  logic [15:0] i_fx_waddr,
    input  logic [7:0]  i_fx_data,
    input  logic [5:0]  i_mod_id,
    output logic        o_vld,
    output logic [7:0]  o_data,
    output src_t        o_src
);

    logic w_fx_ev;
    logic w_spi_hdr;
    logic w_fx_hdr;

    assign w_fx_ev   = i_fx_wr && (i_fx_waddr[15:10] == i_mod_id)
                               && (i_fx_waddr[9:0] == FX_PORT_OFS);
    assign w_spi_hdr = i_spi_vld && (i_spi_data == HDR);
    assign w_fx_hdr  = w_fx_ev && (i_fx_data == HDR);

    always_comb begin
        o_vld = 1'b0;
        o_src = i_grant;
        if (i_idle) begin
            // In IDLE only a header byte can open a frame; anything else is dropped.
            if (w_spi_hdr && w_fx_hdr) begin
                o_src = i_mcu_sel ? SRC_SPI : SRC_FX;
            end else if (w_spi_hdr) begin
                o_src = SRC_SPI;
            end else if (w_fx_hdr) begin
                o_src = SRC_FX;
            end
            o_vld = w_spi_hdr || w_fx_hdr;
        end else begin
            o_vld = (i_grant == SRC_SPI) ? i_spi_vld : w_fx_ev;
        end
        o_data = (o_src == SRC_SPI) ? i_spi_data : i_fx_data;
    end

endmodule

// File: rtl/ex_push_arb.sv
// Frame sequencer in front of the 256-bit push register: header, 32 payload
// bytes, optional checksum byte (EX_PUSH_CKSUM_EN), atomic commit to exp_data.
module ex_push_arb
    import ex_pkg::*;
(
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic [7:0]   spi_data,
    input  logic         spi_vld,
    input  logic         mcu_sel,
    input  logic         fx_wr,
    input  logic [15:0]  fx_waddr,
    input  logic [7:0]   fx_data,
    input  logic [5:0]   mod_id,
    output logic [255:0] exp_data,
    output logic         exp_vld,
    output logic         frm_err,
    output logic         busy,
    output logic         src_cur
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTE - 1);

    state_t             r_state;
    src_t               r_src;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_idle;
    logic [NBYTE*8-1:0] r_shadow;
    logic [NBYTE*8-1:0] r_exp_data;
    logic               r_exp_vld;
    logic               r_frm_err;
    logic               r_busy;
`ifdef EX_PUSH_CKSUM_EN
    logic [7:0]         r_sum;
`endif

    logic               w_vld;
    logic [7:0]         w_byte;
    src_t               w_src;
    logic               w_timeout;

    ex_src_mux u_src_mux (
        .i_idle     (r_state == IDLE),
        .i_grant    (r_src),
        .i_mcu_sel  (mcu_sel),
        .i_spi_vld  (spi_vld),
        .i_spi_data (spi_data),
        .i_fx_wr    (fx_wr),
        .i_fx_waddr (fx_waddr),
        .i_fx_data  (fx_data),
        .i_mod_id   (mod_id),
        .o_vld      (w_vld),
        .o_data     (w_byte),
        .o_src      (w_src)
    );

    assign w_timeout = (r_state != IDLE) && !w_vld && (r_idle == TIMEOUT - 16'd1);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_src      <= SRC_SPI;
            r_cnt      <= '0;
            r_idle     <= '0;
            r_shadow   <= '0;
            r_exp_data <= '0;
            r_exp_vld  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_busy     <= 1'b0;
`ifdef EX_PUSH_CKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_exp_vld <= 1'b0;
            r_frm_err <= 1'b0;
            if (w_timeout) begin
                // Stalled frame: the partial shadow is simply never committed.
                r_frm_err <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= IDLE;
            end else begin
                if (r_state != IDLE) begin
                    r_idle <= w_vld ? 16'd0 : r_idle + 16'd1;
                end
                case (r_state)
                    IDLE: begin
                        if (w_vld) begin
                            r_src   <= w_src;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_idle  <= '0;
                            r_state <= LOAD;
`ifdef EX_PUSH_CKSUM_EN
                            r_sum   <= '0;
`endif
                        end
                    end
                    LOAD: begin
                        if (w_vld) begin
                            r_shadow[{r_cnt, 3'b000} +: 8] <= w_byte;
                            r_cnt <= r_cnt + 1'b1;
`ifdef EX_PUSH_CKSUM_EN
                            r_sum <= r_sum + w_byte;
                            if (r_cnt == LAST) begin
                                r_state <= CKSUM;
                            end
`else
                            if (r_cnt == LAST) begin
                                r_exp_data <= {w_byte, r_shadow[NBYTE*8-9:0]};
                                r_exp_vld  <= 1'b1;
                                r_busy     <= 1'b0;
                                r_state    <= IDLE;
                            end
`endif
                        end
                    end
`ifdef EX_PUSH_CKSUM_EN
                    CKSUM: begin
                        if (w_vld) begin
                            if (w_byte == r_sum) begin
                                r_exp_data <= r_shadow;
                                r_exp_vld  <= 1'b1;
                            end else begin
                                r_frm_err  <= 1'b1;
                            end
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
`endif
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign exp_data = r_exp_data;
    assign exp_vld  = r_exp_vld;
    assign frm_err  = r_frm_err;
    assign busy     = r_busy;
    assign src_cur  = r_src;

endmodule

// File: tb/tb_ex_push_arb.sv
// Directed bench for ex_push_arb; follows EX_PUSH_CKSUM_EN if it is defined
// for the build.
module tb_ex_push_arb;

    logic         clk_sys = 1'b0;
    logic         rst_n;
    logic [7:0]   spi_data;
    logic         spi_vld;
    logic         mcu_sel;
    logic         fx_wr;
    logic [15:0]  fx_waddr;
    logic [7:0]   fx_data;
    logic [5:0]   mod_id;
    logic [255:0] exp_data;
    logic         exp_vld;
    logic         frm_err;
    logic         busy;
    logic         src_cur;

    int           n_vec = 0;
    int           n_err = 0;
    logic [255:0] last_frame;

    localparam logic [5:0]  MOD    = 6'h2B;
    localparam logic [15:0] FX_ADR = {6'h2B, 10'h080};
    localparam logic [7:0]  HDRB   = 8'hA5;

    ex_push_arb dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .spi_data (spi_data),
        .spi_vld  (spi_vld),
        .mcu_sel  (mcu_sel),
        .fx_wr    (fx_wr),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .mod_id   (mod_id),
        .exp_data (exp_data),
        .exp_vld  (exp_vld),
        .frm_err  (frm_err),
        .busy     (busy),
        .src_cur  (src_cur)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One clock with optional bytes on each source; inputs return idle afterwards.
    task automatic step(input logic sv, input logic [7:0] sd,
                        input logic fv, input logic [7:0] fd,
                        input logic [15:0] adr);
        spi_vld  = sv;
        spi_data = sd;
        fx_wr    = fv;
        fx_data  = fd;
        fx_waddr = adr;
        tick();
        spi_vld  = 1'b0;
        fx_wr    = 1'b0;
    endtask

    task automatic send_hdr(input logic src);
        step(src == 1'b0, HDRB, src == 1'b1, HDRB, FX_ADR);
    endtask

    // 32 payload bytes base, base+1, ... (plus checksum when enabled), checks commit.
    task automatic send_body(input string tag, input logic src, input logic [7:0] base,
                             input logic noise);
        logic [255:0] pl;
        logic [7:0]   sum;
        logic [7:0]   b;
        pl  = '0;
        sum = 8'h00;
        for (int k = 0; k < 32; k++) begin
            b = base + 8'(k);
            pl[8*k +: 8] = b;
            sum = sum + b;
            if (src == 1'b0) step(1'b1, b, noise, 8'h11, FX_ADR);
            else             step(noise, 8'h11, 1'b1, b, FX_ADR);
        end
`ifdef EX_PUSH_CKSUM_EN
        chk({tag, "_vld_pre"}, {255'd0, exp_vld}, 256'd0);
        if (src == 1'b0) step(1'b1, sum, noise, 8'h11, FX_ADR);
        else             step(noise, 8'h11, 1'b1, sum, FX_ADR);
`endif
        chk({tag, "_vld"},  {255'd0, exp_vld}, 256'd1);
        chk({tag, "_data"}, exp_data, pl);
        chk({tag, "_err"},  {255'd0, frm_err}, 256'd0);
        chk({tag, "_busy"}, {255'd0, busy}, 256'd0);
        chk({tag, "_src"},  {255'd0, src_cur}, {255'd0, src});
        last_frame = pl;
    endtask

    initial begin
        rst_n    = 1'b0;
        spi_data = 8'h00;
        spi_vld  = 1'b0;
        mcu_sel  = 1'b0;
        fx_wr    = 1'b0;
        fx_waddr = 16'h0000;
        fx_data  = 8'h00;
        mod_id   = MOD;
        last_frame = '0;

        // Reset state
        #12;
        chk("rst_data", exp_data, 256'd0);
        chk("rst_ctl", {251'd0, exp_vld, frm_err, busy, src_cur}, 256'd0);
        rst_n = 1'b1;
        tick();

        // Idle drops: non-header SPI byte, header on wrong fx address
        step(1'b1, 8'h3C, 1'b0, 8'h00, FX_ADR);
        chk("idle_nonhdr_busy", {255'd0, busy}, 256'd0);
        step(1'b0, 8'h00, 1'b1, HDRB, {6'h2A, 10'h080});
        chk("idle_badid_busy", {255'd0, busy}, 256'd0);
        step(1'b0, 8'h00, 1'b1, HDRB, {6'h2B, 10'h081});
        chk("idle_badofs_busy", {255'd0, busy}, 256'd0);

        // SPI frame 00..1F
        send_hdr(1'b0);
        chk("spi_hdr_busy", {255'd0, busy}, 256'd1);
        send_body("spi0", 1'b0, 8'h00, 1'b0);
        chk("spi0_byte0", {248'd0, exp_data[7:0]}, 256'h00);
        chk("spi0_byte31", {248'd0, exp_data[255:248]}, 256'h1F);
        tick();
        chk("spi0_vld_once", {255'd0, exp_vld}, 256'd0);

        // fx frame with SPI noise mid-frame; contains A5 as payload (0x90+0x15)
        send_hdr(1'b1);
        chk("fx_hdr_src", {255'd0, src_cur}, 256'd1);
        send_body("fx_noise", 1'b1, 8'h90, 1'b1);

        // Header tie with mcu_sel=0 -> fx, starting right after commit
        mcu_sel = 1'b0;
        step(1'b1, HDRB, 1'b1, HDRB, FX_ADR);
        chk("tie0_src", {255'd0, src_cur}, 256'd1);
        send_body("tie0", 1'b1, 8'h20, 1'b0);

        // Header tie with mcu_sel=1 -> SPI
        mcu_sel = 1'b1;
        step(1'b1, HDRB, 1'b1, HDRB, FX_ADR);
        chk("tie1_src", {255'd0, src_cur}, 256'd0);
        send_body("tie1", 1'b0, 8'hE8, 1'b0);

`ifdef EX_PUSH_CKSUM_EN
        // Bad checksum: frame 00..1F followed by 0x00 instead of 0xF0
        send_hdr(1'b0);
        for (int k = 0; k < 32; k++) step(1'b1, 8'(k), 1'b0, 8'h00, FX_ADR);
        step(1'b1, 8'h00, 1'b0, 8'h00, FX_ADR);
        chk("badck_err", {255'd0, frm_err}, 256'd1);
        chk("badck_vld", {255'd0, exp_vld}, 256'd0);
        chk("badck_busy", {255'd0, busy}, 256'd0);
        chk("badck_hold", exp_data, last_frame);
        tick();
        chk("badck_err_once", {255'd0, frm_err}, 256'd0);
`else
        tick();
        chk("hold_data", exp_data, last_frame);
        chk("hold_err", {255'd0, frm_err}, 256'd0);
`endif

        // Timeout: header + 10 bytes then idle
        send_hdr(1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, 8'h70 + 8'(k), 1'b0, 8'h00, FX_ADR);
        repeat (49999) tick();
        chk("to_pre_err", {255'd0, frm_err}, 256'd0);
        chk("to_pre_busy", {255'd0, busy}, 256'd1);
        tick();
        chk("to_err", {255'd0, frm_err}, 256'd1);
        chk("to_busy", {255'd0, busy}, 256'd0);
        chk("to_vld", {255'd0, exp_vld}, 256'd0);
        chk("to_hold", exp_data, last_frame);
        tick();
        chk("to_err_once", {255'd0, frm_err}, 256'd0);
        send_hdr(1'b0);
        send_body("after_to", 1'b0, 8'h40, 1'b0);

        // Reset after 5 payload bytes of an fx frame
        send_hdr(1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 8'hC0 + 8'(k), FX_ADR);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_data", exp_data, 256'd0);
        chk("midrst_ctl", {251'd0, exp_vld, frm_err, busy, src_cur}, 256'd0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("postrst_busy", {255'd0, busy}, 256'd0);
        send_hdr(1'b0);
        send_body("postrst", 1'b0, 8'h55, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
